warning_chime: RTL and testbench
================================

Name: warning_chime

Overview:
Sequential stage directly downstream of the combinational car-warning alarm logic. Consumes its level `Alarm` output and qualifies it against glitches. Converts a qualified alarm into a bounded, periodic buzzer pattern with driver acknowledge/mute. Drives the cabin buzzer and a status indication.

Parameters:
QUAL_CYCLES, 4, consecutive high samples of Alarm required before beeping starts (>=1)
ON_CYCLES, 8, clock cycles Buzzer is high per beep (>=1)
OFF_CYCLES, 8, clock cycles Buzzer is low between beeps (>=1)
BEEP_COUNT, 3, beeps issued before automatic mute (1..255)
CNT_W, 16, width of internal timing counter; must hold max(QUAL_CYCLES, ON_CYCLES, OFF_CYCLES)

Ports:
Clk  input  1  system clock, rising-edge
Reset  input  1  asynchronous, active-high reset
Alarm  input  1  raw alarm level from upstream warning logic
Ack  input  1  driver acknowledge/mute request, level, sampled on Clk
Buzzer  output  1  buzzer drive, registered
Active  output  1  high while the warning is qualified (beeping or muted), registered
BeepCnt  output  8  completed beeps in the current alarm episode, registered

Behaviour:
- Reset is asynchronous and active-high: state=IDLE, timer=0, Buzzer=0, Active=0, BeepCnt=0. Reset asserted mid-pattern aborts immediately (no completion of the current beep).
- All outputs are registered and decoded from the next state: Buzzer=1 only in BEEP_ON; Active=1 in BEEP_ON, BEEP_OFF, MUTED.
- IDLE:
  - Alarm=1 sampled -> QUALIFY with timer=1.
  - Alarm=0 -> stay.
- QUALIFY:
  - Alarm=0 -> IDLE and timer=0; the run restarts from zero.
  - Alarm=1 and timer==QUAL_CYCLES-1 -> BEEP_ON with timer=0.
  - Otherwise timer++.
  - Effect: Buzzer rises on the edge that samples the QUAL_CYCLES-th consecutive Alarm=1.
  - QUAL_CYCLES=1: IDLE goes directly to BEEP_ON on the first high sample.
- BEEP_ON:
  - Stays ON_CYCLES cycles, then BEEP_OFF with timer=0; BeepCnt increments on this transition.
- BEEP_OFF:
  - Stays OFF_CYCLES cycles.
  - If BeepCnt==BEEP_COUNT -> MUTED; otherwise -> BEEP_ON.
- MUTED:
  - Buzzer=0, Active=1, BeepCnt held.
  - Exits to IDLE only when Alarm=0 is sampled.
- Ack=1 sampled in BEEP_ON or BEEP_OFF -> MUTED next edge.
  - A beep cut short by Ack does not increment BeepCnt.
  - Ack ignored in IDLE and QUALIFY (cannot pre-mute).
- Alarm=0 sampled in BEEP_ON, BEEP_OFF or MUTED -> IDLE next edge; Buzzer=0, Active=0, BeepCnt=0 together.
- Simultaneous events:
  - Alarm=0 has priority over Ack and over timer expiry.
  - Ack has priority over timer expiry.
- Re-trigger after return to IDLE requires full requalification; BeepCnt restarts from 0.
- Timer never wraps: it is cleared on every state change and bounded by the parameter limits.

Test Plan:
- Reset=1 with Alarm=1 held -> Buzzer=0, Active=0, BeepCnt=0. Release Reset -> Buzzer rises exactly 4 edges later.
- Alarm high 3 cycles, low 1, high 4 -> no beep from the 3-cycle pulse. Buzzer rises on the 4th sample of the second run.
- Alarm held high with defaults -> Buzzer pattern 8 high/8 low x3, BeepCnt steps 1,2,3. MUTED (Buzzer=0, Active=1) entered 48 cycles after the first Buzzer rise. Alarm low -> IDLE next edge, BeepCnt=0.
- Ack=1 for one cycle during the 2nd BEEP_ON, 3 cycles into it -> Buzzer=0 next edge, Active stays 1, BeepCnt=1 held. Alarm low later -> Active=0.
- Alarm=0 and Ack=1 on the same edge during BEEP_OFF -> IDLE (Active=0, BeepCnt=0), not MUTED.
- Async Reset pulse mid-BEEP_ON, between clock edges -> Buzzer=0 immediately without waiting for an edge. Alarm still high -> requalifies, Buzzer rises 4 edges after Reset release.

Source files
------------

// File: rtl/warning_chime.sv
// warning_chime: qualifies the upstream Alarm level and plays a bounded, mutable beep pattern.
// Revision 1.0
`timescale 1ns/1ps
`default_nettype none

module warning_chime #(
  parameter int QUAL_CYCLES = 4,
  parameter int ON_CYCLES   = 8,
  parameter int OFF_CYCLES  = 8,
  parameter int BEEP_COUNT  = 3,
  parameter int CNT_W       = 16
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Alarm,
  input  logic       Ack,
  output logic       Buzzer,
  output logic       Active,
  output logic [7:0] BeepCnt
);

  localparam logic [CNT_W-1:0] QUAL_LAST  = CNT_W'(QUAL_CYCLES - 1);
  localparam logic [CNT_W-1:0] ON_LAST    = CNT_W'(ON_CYCLES - 1);
  localparam logic [CNT_W-1:0] OFF_LAST   = CNT_W'(OFF_CYCLES - 1);
  localparam logic [7:0]       BEEP_LIMIT = 8'(BEEP_COUNT);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    QUALIFY  = 3'd1,
    BEEP_ON  = 3'd2,
    BEEP_OFF = 3'd3,
    MUTED    = 3'd4
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] timer, timer_nxt;
  logic [7:0]       beep_nxt;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state   <= IDLE;
      timer   <= '0;
      Buzzer  <= 1'b0;
      Active  <= 1'b0;
      BeepCnt <= 8'd0;
    end else begin
      state   <= state_nxt;
      timer   <= timer_nxt;
      Buzzer  <= (state_nxt == BEEP_ON);
      Active  <= (state_nxt == BEEP_ON) || (state_nxt == BEEP_OFF) || (state_nxt == MUTED);
      BeepCnt <= beep_nxt;
    end
  end

  // Priority in every active state: Alarm drop, then Ack, then timer expiry.
  always_comb begin
    state_nxt = state;
    timer_nxt = timer;
    beep_nxt  = BeepCnt;
    case (state)
      IDLE: begin
        if (Alarm) begin
          if (QUAL_CYCLES == 1) begin
            state_nxt = BEEP_ON;
            timer_nxt = '0;
          end else begin
            state_nxt = QUALIFY;
            timer_nxt = CNT_W'(1);
          end
        end
      end
      QUALIFY: begin
        if (!Alarm) begin
          state_nxt = IDLE;
          timer_nxt = '0;
        end else if (timer == QUAL_LAST) begin
          state_nxt = BEEP_ON;
          timer_nxt = '0;
        end else begin
          timer_nxt = timer + CNT_W'(1);
        end
      end
      BEEP_ON: begin
        if (!Alarm) begin
          state_nxt = IDLE;
          timer_nxt = '0;
          beep_nxt  = 8'd0;
        end else if (Ack) begin
          state_nxt = MUTED;
          timer_nxt = '0;
        end else if (timer == ON_LAST) begin
          state_nxt = BEEP_OFF;
          timer_nxt = '0;
          beep_nxt  = BeepCnt + 8'd1;
        end else begin
          timer_nxt = timer + CNT_W'(1);
        end
      end
      BEEP_OFF: begin
        if (!Alarm) begin
          state_nxt = IDLE;
          timer_nxt = '0;
          beep_nxt  = 8'd0;
        end else if (Ack) begin
          state_nxt = MUTED;
          timer_nxt = '0;
        end else if (timer == OFF_LAST) begin
          state_nxt = (BeepCnt == BEEP_LIMIT) ? MUTED : BEEP_ON;
          timer_nxt = '0;
        end else begin
          timer_nxt = timer + CNT_W'(1);
        end
      end
      MUTED: begin
        if (!Alarm) begin
          state_nxt = IDLE;
          timer_nxt = '0;
          beep_nxt  = 8'd0;
        end
      end
      default: begin
        state_nxt = IDLE;
        timer_nxt = '0;
        beep_nxt  = 8'd0;
      end
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_warning_chime.sv
// Directed bench for warning_chime: a cycle-level pattern model feeds a scoreboard queue.
`timescale 1ns/1ps
`default_nettype none

module tb_warning_chime;

  localparam int QUAL = 4;
  localparam int ON   = 8;
  localparam int OFF  = 8;
  localparam int NB   = 3;
  localparam int P    = ON + OFF;

  logic       Clk = 1'b0;
  logic       Reset;
  logic       Alarm;
  logic       Ack;
  logic       Buzzer;
  logic       Active;
  logic [7:0] BeepCnt;

  int checks   = 0;
  int failures = 0;
  int nstep    = 0;

  logic [9:0] sb[$];

  // Model: mode 0 idle/qualifying, 1 beeping (pos = cycles since first beep), 2 muted.
  int         m_mode, m_q, m_pos;
  logic [7:0] m_cnt;

  warning_chime #(
    .QUAL_CYCLES(QUAL), .ON_CYCLES(ON), .OFF_CYCLES(OFF), .BEEP_COUNT(NB), .CNT_W(16)
  ) dut (
    .Clk(Clk), .Reset(Reset), .Alarm(Alarm), .Ack(Ack),
    .Buzzer(Buzzer), .Active(Active), .BeepCnt(BeepCnt)
  );

  always #5 Clk = ~Clk;

  function automatic logic [7:0] done_beeps(input int pos);
    return 8'(pos / P + (((pos % P) >= ON) ? 1 : 0));
  endfunction

  function automatic logic [9:0] model_out();
    if (m_mode == 1) return {((m_pos % P) < ON), 1'b1, done_beeps(m_pos)};
    if (m_mode == 2) return {1'b0, 1'b1, m_cnt};
    return 10'd0;
  endfunction

  task automatic model_reset();
    m_mode = 0; m_q = 0; m_pos = 0; m_cnt = 8'd0;
  endtask

  task automatic model_edge(input logic a, input logic k);
    if (!a) begin
      model_reset();
    end else begin
      case (m_mode)
        0: begin
          m_q++;
          if (m_q >= QUAL) begin m_mode = 1; m_pos = 0; m_q = 0; end
        end
        1: begin
          if (k) begin
            m_cnt  = done_beeps(m_pos);
            m_mode = 2;
          end else begin
            m_pos++;
            if (m_pos == NB * P) begin m_mode = 2; m_cnt = 8'(NB); end
          end
        end
        default: ;
      endcase
    end
  endtask

  task automatic check(input string tag);
    logic [9:0] exp;
    logic [9:0] obs;
    obs = {Buzzer, Active, BeepCnt};
    checks++;
    if (sb.size() == 0) begin
      failures++;
      $error("FAIL %s: scoreboard empty, observed %h", tag, obs);
    end else begin
      exp = sb.pop_front();
      assert (obs === exp) else begin
        failures++;
        $error("FAIL %s: observed buz=%b act=%b cnt=%0d expected buz=%b act=%b cnt=%0d",
               tag, obs[9], obs[8], obs[7:0], exp[9], exp[8], exp[7:0]);
      end
    end
  endtask

  task automatic step(input logic a, input logic k);
    Alarm = a;
    Ack   = k;
    @(posedge Clk);
    model_edge(a, k);
    sb.push_back(model_out());
    nstep++;
    #1 check($sformatf("step%0d", nstep));
  endtask

  task automatic run(input logic a, input int n);
    for (int i = 0; i < n; i++) step(a, 1'b0);
  endtask

  initial begin
    // Reset held with Alarm high keeps everything quiet.
    Reset = 1'b1; Alarm = 1'b1; Ack = 1'b0;
    model_reset();
    #16;
    sb.push_back(10'd0);
    check("reset_hold");
    Reset = 1'b0;

    // Buzzer rises on the 4th edge after release, then drop Alarm.
    run(1'b1, 6);
    run(1'b0, 2);

    // 3-cycle glitch then a full run through the complete pattern and auto-mute.
    run(1'b1, 3);
    run(1'b0, 1);
    run(1'b1, 4 + NB * P + 4);
    run(1'b0, 2);

    // Ack three cycles into the 2nd beep.
    run(1'b1, 4 + P + 3);
    step(1'b1, 1'b1);
    run(1'b1, 3);
    run(1'b0, 2);

    // Alarm drop and Ack together in BEEP_OFF: Alarm wins.
    run(1'b1, 4 + 10);
    step(1'b0, 1'b1);
    step(1'b0, 1'b0);

    // Ack during BEEP_OFF mutes with the completed beep kept.
    run(1'b1, 4 + 11);
    step(1'b1, 1'b1);
    run(1'b1, 2);
    run(1'b0, 1);

    // Asynchronous reset pulse between edges mid-beep.
    run(1'b1, 4 + 3);
    Reset = 1'b1;
    #2;
    model_reset();
    sb.push_back(10'd0);
    check("async_reset");
    #1 Reset = 1'b0;
    run(1'b1, 6);
    run(1'b0, 2);

    if (sb.size() != 0) begin
      checks++;
      failures++;
      $error("FAIL sb_drain: %0d entries left, expected 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
